// File: rtl/control_sequencer_pkg.sv
// Opcodes and branch-condition decode shared by the sequencer, its interface and its bench.
// Pure declarations; no latency or flow control of its own.
package control_sequencer_pkg;

    localparam int FLAGS_W = 5;

    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_JTYPE = 4'h8;
    localparam logic [3:0] OP_LOAD  = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;
    localparam logic [3:0] OP_WAIT  = 4'hB;
    localparam logic [3:0] OP_BCOND = 4'hC;

    // cc[3] inverts the sense; selectors 5..7 branch unconditionally, ignoring cc[3].
    function automatic logic bcond_taken(input logic [FLAGS_W-1:0] flags, input logic [3:0] cc);
        logic taken;
        case (cc[2:0])
            3'd0:    taken = flags[0] ^ cc[3];
            3'd1:    taken = flags[1] ^ cc[3];
            3'd2:    taken = flags[2] ^ cc[3];
            3'd3:    taken = flags[3] ^ cc[3];
            3'd4:    taken = flags[4] ^ cc[3];
            default: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Memory/ALU/register-file control bundle between the sequencer (master) and the datapath (slave).
// Wires only; memory stalls are signalled by mem_ready.
interface control_sequencer_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    import control_sequencer_pkg::*;

    logic [DATA_W-1:0]  instr;
    logic [DATA_W-1:0]  alu_c;
    logic [FLAGS_W-1:0] alu_flags;
    logic               mem_ready;

    logic [ADDR_W-1:0]  pc;
    logic               addr_sel;
    logic               mem_we;
    logic               reg_we;
    logic               wb_sel;
    logic               op_override;
    logic [DATA_W-1:0]  alu_op;
    logic [3:0]         reg_wr;
    logic [3:0]         reg_rd_a;
    logic [3:0]         reg_rd_b;
    logic [FLAGS_W-1:0] saved_flags;
    logic               busy_wait;

    modport master (
        input  instr, alu_c, alu_flags, mem_ready,
        output pc, addr_sel, mem_we, reg_we, wb_sel, op_override, alu_op,
               reg_wr, reg_rd_a, reg_rd_b, saved_flags, busy_wait
    );

    modport slave (
        output instr, alu_c, alu_flags, mem_ready,
        input  pc, addr_sel, mem_we, reg_we, wb_sel, op_override, alu_op,
               reg_wr, reg_rd_a, reg_rd_b, saved_flags, busy_wait
    );

endinterface

// File: rtl/control_sequencer_wait_timer.sv
// Millisecond timer: tick divider of TICK_DIV+1 cycles feeding a WAIT_W-bit ms counter.
// Counts only while en_i is high; clr_i has priority and zeroes both counters next cycle.
module control_sequencer_wait_timer #(
    parameter int TICK_DIV = 33333,
    parameter int TICK_W   = 16,
    parameter int WAIT_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              clr_i,
    output logic [WAIT_W-1:0] ms_o
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [WAIT_W-1:0] ms_q, ms_d;

    always_comb begin
        tick_d = tick_q;
        ms_d   = ms_q;
        if (clr_i) begin
            tick_d = '0;
            ms_d   = '0;
        end else if (en_i) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                ms_d   = ms_q + WAIT_W'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q <= '0;
            ms_q   <= '0;
        end else begin
            tick_q <= tick_d;
            ms_q   <= ms_d;
        end
    end

    assign ms_o = ms_q;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode sequencer owning PC, saved flags and WAIT timer; CPI 3 (LOAD 4, WAIT 3+ms*(TICK_DIV+1)).
// FETCH, LOAD1 and STORE hold until mem_ready; all decoded outputs are Moore and forced low during reset.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 15,
    parameter int                DATA_W   = 16,
    parameter int                WAIT_W   = 12,
    parameter int                TICK_DIV = 33333,
    parameter int                TICK_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    control_sequencer_if.master  seq_io
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_JUMP   = 4'd3,
        S_LOAD1  = 4'd4,
        S_LOAD2  = 4'd5,
        S_STORE  = 4'd6,
        S_BRANCH = 4'd7,
        S_WAIT   = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;

    logic              addr_sel, mem_we, reg_we, wb_sel, op_override, busy_wait;
    logic              tmr_en, tmr_clr;
    logic [WAIT_W-1:0] tmr_ms;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] pc_dec;
    logic [ADDR_W-1:0] br_off;

    assign opcode = seq_io.instr[DATA_W-1 -: 4];
    assign pc_dec = pc_q - ADDR_W'(1);
    assign br_off = {{(ADDR_W-8){seq_io.instr[7]}}, seq_io.instr[7:0]};

    control_sequencer_wait_timer #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .en_i  (tmr_en),
        .clr_i (tmr_clr),
        .ms_o  (tmr_ms)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flags_d     = flags_q;
        addr_sel    = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        op_override = 1'b0;
        busy_wait   = 1'b0;
        tmr_en      = 1'b0;
        tmr_clr     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (seq_io.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_JTYPE: state_d = S_JUMP;
                    OP_LOAD:  state_d = S_LOAD1;
                    OP_STORE: state_d = S_STORE;
                    OP_WAIT:  state_d = S_WAIT;
                    OP_BCOND: state_d = S_BRANCH;
                    default:  state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                reg_we  = 1'b1;
                flags_d = seq_io.alu_flags;
                pc_d    = pc_dec;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                op_override = 1'b1;
                pc_d        = seq_io.alu_c[ADDR_W-1:0];
                state_d     = S_FETCH;
            end
            S_LOAD1: begin
                addr_sel = 1'b1;
                if (seq_io.mem_ready) state_d = S_LOAD2;
            end
            S_LOAD2: begin
                wb_sel  = 1'b1;
                reg_we  = 1'b1;
                pc_d    = pc_dec;
                state_d = S_FETCH;
            end
            S_STORE: begin
                addr_sel    = 1'b1;
                op_override = 1'b1;
                mem_we      = 1'b1;
                if (seq_io.mem_ready) begin
                    pc_d    = pc_dec;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                pc_d    = bcond_taken(flags_q, seq_io.instr[11:8]) ? (pc_q - br_off) : pc_dec;
                state_d = S_FETCH;
            end
            S_WAIT: begin
                // Compare before counting so a zero operand leaves on the first WAIT cycle.
                if (tmr_ms == seq_io.instr[WAIT_W-1:0]) begin
                    tmr_clr = 1'b1;
                    pc_d    = pc_dec;
                    state_d = S_FETCH;
                end else begin
                    busy_wait = 1'b1;
                    tmr_en    = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    // Gating with reset keeps instr-derived fields quiet while the core is held.
    assign seq_io.pc          = pc_q;
    assign seq_io.saved_flags = flags_q;
    assign seq_io.addr_sel    = reset & addr_sel;
    assign seq_io.mem_we      = reset & mem_we;
    assign seq_io.reg_we      = reset & reg_we;
    assign seq_io.wb_sel      = reset & wb_sel;
    assign seq_io.op_override = reset & op_override;
    assign seq_io.busy_wait   = reset & busy_wait;
    assign seq_io.reg_wr      = reset ? seq_io.instr[11:8] : 4'h0;
    assign seq_io.reg_rd_a    = reset ? seq_io.instr[11:8] : 4'h0;
    assign seq_io.reg_rd_b    = reset ? seq_io.instr[3:0]  : 4'h0;
    assign seq_io.alu_op      = reset ? {OP_ADDI, seq_io.instr[11:8], {(DATA_W-8){1'b0}}} : '0;

    generate
        if (DATA_W > ADDR_W) begin : g_alu_c_hi
            logic unused_alu_c_hi;
            assign unused_alu_c_hi = ^seq_io.alu_c[DATA_W-1:ADDR_W];
        end
    endgenerate

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised scoreboard bench for control_sequencer against a per-instruction behavioural model.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 16;
    localparam int WAIT_W   = 12;
    localparam int TICK_DIV = 3;
    localparam int TICK_W   = 4;
    localparam int PC_MASK  = (1 << ADDR_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic boundary = 1'b0;

    control_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    control_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAIT_W   (WAIT_W),
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W),
        .PC_RESET ('1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .seq_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int flags;
        int n_reg_we;
        int n_wb;
        int n_mem_we;
        int n_addr;
        int n_ovr;
        int n_busy;
        int reg_wr;
        int alu_op;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_pc;
    int   m_flags;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pc"},     int'(bus.pc), PC_MASK);
        check({tag, "_flags"},  int'(bus.saved_flags), 0);
        check({tag, "_ctrl"},   int'({bus.reg_we, bus.mem_we, bus.addr_sel, bus.wb_sel,
                                      bus.op_override, bus.busy_wait}), 0);
        check({tag, "_fields"}, int'({bus.reg_wr, bus.reg_rd_a, bus.reg_rd_b}), 0);
        check({tag, "_alu_op"}, int'(bus.alu_op), 0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop before the next edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1 check_quiet("midrst");
        boundary = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        m_pc    = PC_MASK;
        m_flags = 0;
    endtask

    task automatic run_instr(input logic [15:0] ins, input int aluc, input int flg,
                             input int fstall, input int mstall, input int abort_at);
        logic [3:0] op;
        obs_t e;
        int   body, npc, nflags, off, k, cycles;
        bit   taken, is_mem;
        op     = ins[15:12];
        e      = '{default: 0};
        npc    = (m_pc - 1) & PC_MASK;
        nflags = m_flags;
        body   = 1;
        is_mem = (op == OP_LOAD) || (op == OP_STORE);
        if (op == OP_JTYPE) begin
            e.n_ovr = 1;
            npc     = aluc & PC_MASK;
        end else if (op == OP_LOAD) begin
            body       = mstall + 2;
            e.n_addr   = mstall + 1;
            e.n_reg_we = 1;
            e.n_wb     = 1;
        end else if (op == OP_STORE) begin
            body       = mstall + 1;
            e.n_addr   = mstall + 1;
            e.n_ovr    = mstall + 1;
            e.n_mem_we = mstall + 1;
        end else if (op == OP_WAIT) begin
            e.n_busy = int'(ins[11:0]) * (TICK_DIV + 1);
            body     = e.n_busy + 1;
        end else if (op == OP_BCOND) begin
            k   = int'(ins[10:8]);
            off = int'(ins[7:0]);
            if (off > 127) off -= 256;
            taken = (k >= 5) ? 1'b1 : ((((m_flags >> k) & 1) != 0) != ins[11]);
            if (taken) npc = (m_pc - off) & PC_MASK;
        end else begin
            e.n_reg_we = 1;
            nflags     = flg;
        end
        if (e.n_reg_we != 0) e.reg_wr = int'(ins[11:8]);
        if (e.n_ovr != 0)    e.alu_op = (int'(OP_ADDI) << 12) | (int'(ins[11:8]) << 8);
        cycles = fstall + 2 + body;
        if (abort_at < 0) begin
            e.pc    = npc;
            e.flags = nflags;
            exp_q.push_back(e);
            m_pc    = npc;
            m_flags = nflags;
        end
        bus.instr     = ins;
        bus.alu_c     = 16'(aluc);
        bus.alu_flags = 5'(flg);
        for (int c = 0; c < cycles; c++) begin
            if (c == abort_at) begin
                do_reset();
                return;
            end
            boundary      = (c == 0);
            bus.mem_ready = !((c < fstall) ||
                              (is_mem && c >= fstall + 2 && c < fstall + 2 + mstall));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        bit   open;
        obs_t a, e;
        open = 1'b0;
        a    = '{default: 0};
        forever begin
            @(negedge clk);
            if (!reset) begin
                open = 1'b0;
                continue;
            end
            if (boundary) begin
                if (open) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", 1, 0);
                    end else begin
                        e       = exp_q.pop_front();
                        a.pc    = int'(bus.pc);
                        a.flags = int'(bus.saved_flags);
                        check("pc",          a.pc,       e.pc);
                        check("saved_flags", a.flags,    e.flags);
                        check("reg_we_cnt",  a.n_reg_we, e.n_reg_we);
                        check("wb_sel_cnt",  a.n_wb,     e.n_wb);
                        check("mem_we_cnt",  a.n_mem_we, e.n_mem_we);
                        check("addr_sel_cnt", a.n_addr,  e.n_addr);
                        check("override_cnt", a.n_ovr,   e.n_ovr);
                        check("busy_cnt",    a.n_busy,   e.n_busy);
                        check("reg_wr",      a.reg_wr,   e.reg_wr);
                        check("alu_op",      a.alu_op,   e.alu_op);
                    end
                end
                open = 1'b1;
                a    = '{default: 0};
            end
            if (open) begin
                a.n_reg_we += int'(bus.reg_we);
                a.n_wb     += int'(bus.wb_sel);
                a.n_mem_we += int'(bus.mem_we);
                a.n_addr   += int'(bus.addr_sel);
                a.n_ovr    += int'(bus.op_override);
                a.n_busy   += int'(bus.busy_wait);
                if (bus.reg_we)      a.reg_wr = int'(bus.reg_wr);
                if (bus.op_override) a.alu_op = int'(bus.alu_op);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [3:0]  op4;
        logic [11:0] lo12;
        bus.instr     = '0;
        bus.alu_c     = '0;
        bus.alu_flags = '0;
        bus.mem_ready = 1'b1;
        m_pc    = PC_MASK;
        m_flags = 0;
        repeat (3) @(posedge clk);
        #1 check_quiet("reset");
        reset = 1'b1;

        run_instr({4'h0, 4'h3, 4'h0, 4'h5}, 16'h1234, 5'h1B, 0, 0, -1);
        run_instr({OP_LOAD, 4'h2, 8'h07}, 0, 0, 0, 3, -1);
        run_instr({OP_STORE, 4'h6, 8'h01}, 0, 0, 0, 2, -1);
        run_instr({OP_JTYPE, 4'h4, 8'h00}, 16'h0101, 0, 0, 0, -1);
        run_instr({4'h2, 4'h1, 8'h00}, 0, 5'b00001, 0, 0, -1);
        run_instr({OP_BCOND, 4'h0, 8'h04}, 0, 0, 0, 0, -1);
        run_instr({OP_JTYPE, 4'h4, 8'h00}, 16'h0101, 0, 0, 0, -1);
        run_instr({4'h2, 4'h1, 8'h00}, 0, 5'b00000, 0, 0, -1);
        run_instr({OP_BCOND, 4'h0, 8'h04}, 0, 0, 0, 0, -1);
        run_instr({OP_JTYPE, 4'h4, 8'h00}, 16'h0101, 0, 1, 0, -1);
        run_instr({4'h2, 4'h1, 8'h00}, 0, 5'b00001, 0, 0, -1);
        run_instr({OP_BCOND, 4'h0, 8'hFE}, 0, 0, 0, 0, -1);
        run_instr({OP_WAIT, 12'd2}, 0, 0, 0, 0, -1);
        run_instr({OP_WAIT, 12'd0}, 0, 0, 0, 0, -1);
        run_instr({OP_JTYPE, 4'h0, 8'h00}, 16'h0000, 0, 0, 0, -1);
        run_instr({OP_BCOND, 4'hF, 8'h00}, 0, 0, 0, 0, -1);

        for (int i = 0; i < 80; i++) begin
            op4  = 4'($urandom_range(0, 15));
            lo12 = 12'($urandom);
            if (op4 == OP_WAIT) lo12 = 12'($urandom_range(0, 3));
            run_instr({op4, lo12}, int'($urandom_range(0, 65535)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
        end

        run_instr({OP_WAIT, 12'd2}, 0, 0, 0, 0, 7);
        run_instr({OP_WAIT, 12'd1}, 0, 0, 0, 0, -1);
        run_instr({4'h3, 4'h7, 8'h00}, 0, 5'h0A, 0, 0, -1);
        run_instr({OP_STORE, 4'h5, 8'h23}, 0, 0, 0, 3, 3);
        run_instr({OP_LOAD, 4'h9, 8'h00}, 0, 0, 0, 1, -1);
        run_instr({OP_BCOND, 4'h8, 8'h10}, 0, 0, 0, 0, -1);

        boundary      = 1'b1;
        bus.mem_ready = 1'b0;
        bus.instr     = '0;
        @(posedge clk);
        #1 boundary = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
